// File: rtl/axi_wr_beat_gen.sv
// AXI4 write-channel slave front end for a 64-bit bus: walks one AW burst beat
// by beat, qualifies WSTRB against the legal lane mask and drives a registered memory write port.
module axi_wr_beat_gen #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [63:0]       wdata,
  input  logic [7:0]        wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_be
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  // Beat addresses stay size-aligned, so the shifted mask never spills past lane 7.
  function automatic logic [7:0] lane_mask(input logic [2:0] lo, input logic [2:0] size);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << lo;
  endfunction

  state_t            state_q, state_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        len_q, len_d, cnt_q, cnt_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              err_q, err_d, aw_err_q, aw_err_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [63:0]       mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_be_q, mem_be_d;

  logic [7:0]        mask;
  logic [ADDR_W-1:0] sz, bnd, next_addr;
  logic              wrap_len_ok, aw_bad, is_last;

  always_comb begin
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    id_d        = id_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    aw_err_d    = aw_err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;

    mask        = lane_mask(cur_addr_q[2:0], size_q);
    sz          = ADDR_W'(1) << size_q;
    bnd         = ADDR_W'({1'b0, len_q} + 9'd1) << size_q;
    is_last     = (cnt_q == len_q);
    wrap_len_ok = (awlen == 8'd1) || (awlen == 8'd3) || (awlen == 8'd7) || (awlen == 8'd15);
    aw_bad      = (awsize > 3'd3) || (awburst == 2'b11) || ((awburst == 2'b10) && !wrap_len_ok);

    case (burst_q)
      2'b01:   next_addr = cur_addr_q + sz;
      2'b10:   next_addr = (cur_addr_q & ~(bnd - ADDR_W'(1))) |
                           ((cur_addr_q + sz) & (bnd - ADDR_W'(1)));
      default: next_addr = cur_addr_q;
    endcase

    case (state_q)
      IDLE: begin
        if (awvalid && awready_q) begin
          state_d    = DATA;
          awready_d  = 1'b0;
          wready_d   = 1'b1;
          id_d       = awid;
          len_d      = awlen;
          size_d     = awsize;
          burst_d    = awburst;
          cur_addr_d = awaddr & ~((ADDR_W'(1) << awsize) - ADDR_W'(1));
          cnt_d      = 8'd0;
          err_d      = aw_bad;
          aw_err_d   = aw_bad;
        end
      end
      DATA: begin
        if (wvalid && wready_q) begin
          mem_we_d    = !aw_err_q;
          mem_be_d    = wstrb & mask;
          mem_addr_d  = {cur_addr_q[ADDR_W-1:3], 3'b000};
          mem_wdata_d = wdata;
          cur_addr_d  = next_addr;
          cnt_d       = cnt_q + 8'd1;
          err_d       = err_q | ((wstrb & ~mask) != 8'h00);
          // Either end marker closes the burst; disagreement between them is an error.
          if (wlast || is_last) begin
            state_d  = RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            if (wlast != is_last) err_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (bready) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          err_d     = 1'b0;
          aw_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awready_q   <= 1'b1;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      aw_err_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      id_q        <= id_d;
      len_q       <= len_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      aw_err_q    <= aw_err_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = id_q;
  assign bresp     = bvalid_q ? {err_q, 1'b0} : 2'b00;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
endmodule
